sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

- Parametrised single-clock FIFO. Successor to the fixed 16-bit × 8 FIFO.
- Adds configurable width and depth, full use of all DEPTH entries, an occupancy count, almost-full/almost-empty thresholds, overflow/underflow error pulses, and an optional first-word-fall-through (FWFT) read mode.
- Sits between a producer and a consumer in the same clock domain; it is the default buffering primitive for new datapath blocks.

## Interface
- `DATA_W`, 16: data width in bits, ≥1.
- `DEPTH`, 8: number of entries; power of two, ≥2.
- `AF_LEVEL`, DEPTH-1: `almost_full` asserts when count ≥ AF_LEVEL; 1..DEPTH.
- `AE_LEVEL`, 1: `almost_empty` asserts when count ≤ AE_LEVEL; 0..DEPTH-1.
- `FWFT`, 0: 0 = registered read; 1 = first-word-fall-through.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `w_en`  in  1  write request.
- `data_in`  in  DATA_W  write data.
- `r_en`  in  1  read request (pop in FWFT mode).
- `data_out`  out  DATA_W  read data.
- `empty`  out  1  count == 0.
- `full`  out  1  count == DEPTH.
- `almost_full`  out  1  count ≥ AF_LEVEL.
- `almost_empty`  out  1  count ≤ AE_LEVEL.
- `count`  out  AW+1  occupancy, 0..DEPTH, where AW = log2(DEPTH).
- `overflow`  out  1  one-cycle pulse: a write was rejected.
- `underflow`  out  1  one-cycle pulse: a read was rejected.

## Operation
- **Pointers:**
  - `wptr` and `rptr` are AW+1 bits; the MSB is the wrap bit. The low AW bits address memory.
  - Both increment by 1 and wrap naturally modulo 2·DEPTH.
- **Flags:**
  - `full` when the MSBs differ and the low bits are equal.
  - `empty` when the pointers are equal.
  - All DEPTH entries are usable.
- **Write accepted** iff `w_en && !full`: `mem[wptr]` ← `data_in`, then `wptr`++.
- **Read accepted** iff `r_en && !empty`: `rptr`++.
- **Acceptance uses flags from the current cycle only.**
  - At full with `w_en` and `r_en` both high: the read is accepted, the write is rejected, and `overflow` pulses.
  - At empty with both high: the write is accepted, the read is rejected, and `underflow` pulses.
- **Both accepted:** `count` is unchanged and both pointers advance.
- **`count`** = `wptr` − `rptr` (AW+1-bit modular subtraction). Registered: +1 on write only, −1 on read only.
- **FWFT=0:** on an accepted read, `data_out` ← `mem[rptr]`. Otherwise `data_out` holds its last value.
- **FWFT=1:** `data_out` = `mem[rptr]` whenever `!empty`, and 0 when empty. `r_en` discards the current head word.
- **Rejected requests:** no state change besides the error pulse.
- **Reset values** (apply immediately, even mid-operation):
  - pointers = 0, `count` = 0, `data_out` = 0
  - `empty` = 1, `full` = 0
  - `almost_empty` = 1, `almost_full` = 0
  - `overflow` = 0, `underflow` = 0
  - Memory contents are not reset and are don't-care.
  - In-flight requests in the reset cycle are dropped.

## Timing
- **Write to flags:** for a write accepted at edge N, `empty`/`count`/`almost_*` reflect it after edge N.
- **Write to data, FWFT=0:** earliest read request is in cycle N+1; data appears on `data_out` after edge N+1. Read latency is 1 cycle from request.
- **Write to data, FWFT=1:** data is visible on `data_out` after edge N, the same cycle `empty` falls.
- **Flags and `count`:** registered or derived from registered pointers only; no combinational path from `w_en`/`r_en` to any output.
- **`overflow`/`underflow`:** registered; high for exactly the cycle after the rejected request.
- **Throughput:** one write and one read per cycle sustained.

## Structure
- Shared package `fifo_pkg`:
  - `clog2` helper function.
  - Default constants `FIFO_DATA_W_DEF` = 16 and `FIFO_DEPTH_DEF` = 8.
- Sub-module `fifo_ram`: DEPTH × DATA_W storage, one synchronous write port and one asynchronous read port addressed by the low AW bits.
- Pointer, flag, count and FWFT output logic stay in `sync_fifo_param`.

## Test plan
- **Reset then idle:** `empty`=1, `almost_empty`=1, `full`=0, `count`=0, `data_out`=0.
- **Fill, DATA_W=16, DEPTH=8:** write 0x0001..0x0008.
  - `count` steps 1..8; `almost_full` rises at count 7; `full` rises after the 8th write.
  - A 9th write pulses `overflow` for 1 cycle; `count` stays 8.
- **Drain, FWFT=0:** read 8 times; `data_out` gives 0x0001..0x0008, each one cycle after its request.
  - `empty` rises after the 8th read.
  - A 9th read pulses `underflow`; `data_out` holds 0x0008.
- **Wrap-around:** run 20 write+read pairs at steady count 3.
  - Data order is preserved across pointer wrap; `count` stays 3.
  - At full with both enables high: the read is accepted, the write is rejected, `overflow`=1, and `count` goes to 7.
- **FWFT=1:** write 0xABCD at edge N; after edge N, `data_out`=0xABCD and `empty`=0.
  - Pulse `r_en`; `data_out` returns to 0 and `empty`=1.
- **Reset mid-operation:** assert `rst` asynchronously with count=5.
  - All outputs take their reset values immediately.
  - After release, a write then read returns the new data only.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO package: default geometry and a constant-foldable log2 helper.
package fifo_pkg;

    localparam int unsigned FIFO_DATA_W_DEF = 16;
    localparam int unsigned FIFO_DEPTH_DEF  = 8;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: DEPTH x DATA_W, one synchronous write port, one asynchronous read port.
//   clk     : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational from i_raddr)
module fifo_ram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned AW     = 3
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds, overflow/underflow pulses and optional first-word-fall-through.
//   clk, rst      : clock, asynchronous active-high reset
//   w_en, data_in : write request and data
//   r_en          : read request (pop in FWFT mode)
//   data_out      : read data (registered, or head word in FWFT mode)
//   empty, full, almost_full, almost_empty, count : occupancy status
//   overflow, underflow : one-cycle pulses after a rejected write/read
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter  int unsigned DATA_W   = FIFO_DATA_W_DEF,
    parameter  int unsigned DEPTH    = FIFO_DEPTH_DEF,
    parameter  int unsigned AF_LEVEL = DEPTH - 1,
    parameter  int unsigned AE_LEVEL = 1,
    parameter  bit          FWFT     = 1'b0,
    localparam int unsigned AW       = clog2(DEPTH),
    localparam int unsigned CW       = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              r_en,
    output logic [DATA_W-1:0] data_out,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [AW:0] AF_THR = CW'(AF_LEVEL);
    localparam logic [AW:0] AE_THR = CW'(AE_LEVEL);

    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic [AW:0]       r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_full;
    logic              w_empty;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [DATA_W-1:0] w_rdata;

    // Flags come only from registered pointers; MSB is the wrap bit.
    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[AW] != r_rptr[AW]) &&
                      (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_wr_acc = w_en && !w_full;
    assign w_rd_acc = r_en && !w_empty;

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wptr[AW-1:0]),
        .i_wdata (data_in),
        .i_raddr (r_rptr[AW-1:0]),
        .o_rdata (w_rdata)
    );

    // Pointers, occupancy and error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_en && w_full;
            r_underflow <= r_en && w_empty;
            if (w_wr_acc) begin
                r_wptr <= r_wptr + CW'(1);
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + CW'(1);
            end
            // Simultaneous accepted read and write leave occupancy unchanged.
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + CW'(1);
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is visible whenever the FIFO holds data.
            assign data_out = w_empty ? '0 : w_rdata;
        end else begin : g_reg
            logic [DATA_W-1:0] r_data_out;

            // Registered read: capture head on an accepted read, else hold.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_data_out <= '0;
                end else if (w_rd_acc) begin
                    r_data_out <= w_rdata;
                end
            end

            assign data_out = r_data_out;
        end
    endgenerate

    assign empty        = w_empty;
    assign full         = w_full;
    assign count        = r_count;
    assign almost_full  = (r_count >= AF_THR);
    assign almost_empty = (r_count <= AE_THR);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Testbench for sync_fifo_param: a registered-read and an FWFT instance share
// the same stimulus and are compared against a queue-based reference model.
module tb_sync_fifo_param;

    localparam int unsigned DW  = 16;
    localparam int unsigned DEP = 8;

    logic          clk;
    logic          rst;
    logic          w_en;
    logic          r_en;
    logic [DW-1:0] data_in;

    logic [DW-1:0] dout0, dout1;
    logic          empty0, full0, af0, ae0, ovf0, unf0;
    logic          empty1, full1, af1, ae1, ovf1, unf1;
    logic [3:0]    count0, count1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_dout0;
    bit            m_ovf;
    bit            m_unf;

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEP), .FWFT(1'b0)) u_reg (
        .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(dout0), .empty(empty0), .full(full0), .almost_full(af0),
        .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEP), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(dout1), .empty(empty1), .full(full1), .almost_full(af1),
        .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(unf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] exp_head();
        return (m_q.size() != 0) ? m_q[0] : '0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_dout0 = '0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // Drive one cycle of requests and advance the model at the clock edge.
    task automatic step(input bit w, input bit r, input logic [DW-1:0] d);
        bit was_full, was_empty;
        w_en    = w;
        r_en    = r;
        data_in = d;
        @(posedge clk);
        was_full  = (m_q.size() == DEP);
        was_empty = (m_q.size() == 0);
        m_ovf = w && was_full;
        m_unf = r && was_empty;
        if (r && !was_empty) m_dout0 = m_q.pop_front();
        if (w && !was_full)  m_q.push_back(d);
        #1;
        w_en = 1'b0;
        r_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        w_en = 1'b0; r_en = 1'b0; data_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b exp 1", empty0); end
        checks++; if (ae0 !== 1'b1)    begin errors++; $display("FAIL reset_ae got %0b exp 1", ae0); end
        checks++; if (full0 !== 1'b0)  begin errors++; $display("FAIL reset_full got %0b exp 0", full0); end
        checks++; if (af0 !== 1'b0)    begin errors++; $display("FAIL reset_af got %0b exp 0", af0); end
        checks++; if (count0 !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count0); end
        checks++; if (dout0 !== 16'h0) begin errors++; $display("FAIL reset_dout0 got %0h exp 0", dout0); end
        checks++; if (dout1 !== 16'h0) begin errors++; $display("FAIL reset_dout1 got %0h exp 0", dout1); end
        checks++; if (ovf0 !== 1'b0 || unf0 !== 1'b0) begin errors++; $display("FAIL reset_err got %0b%0b exp 00", ovf0, unf0); end
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0, '0);
        checks++; if (empty0 !== 1'b1 || count0 !== 4'd0) begin errors++; $display("FAIL idle got empty=%0b count=%0d exp 1/0", empty0, count0); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 16'(i));
            checks++; if (count0 !== 4'(i)) begin errors++; $display("FAIL fill_count got %0d exp %0d", count0, i); end
            checks++; if (af0 !== (i >= 7)) begin errors++; $display("FAIL fill_af got %0b exp %0b at %0d", af0, (i >= 7), i); end
            checks++; if (full0 !== (i == 8)) begin errors++; $display("FAIL fill_full got %0b exp %0b at %0d", full0, (i == 8), i); end
            checks++; if (ae0 !== (i <= 1)) begin errors++; $display("FAIL fill_ae got %0b exp %0b at %0d", ae0, (i <= 1), i); end
            checks++; if (dout1 !== 16'h0001) begin errors++; $display("FAIL fill_fwft_head got %0h exp 1", dout1); end
        end
        step(1'b1, 1'b0, 16'h0009);
        checks++; if (ovf0 !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %0b exp 1", ovf0); end
        checks++; if (count0 !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d exp 8", count0); end
        step(1'b0, 1'b0, '0);
        checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle got %0b exp 0", ovf0); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, '0);
            checks++; if (dout0 !== 16'(i)) begin errors++; $display("FAIL drain_data got %0h exp %0h", dout0, i); end
            checks++; if (dout1 !== exp_head()) begin errors++; $display("FAIL drain_fwft got %0h exp %0h", dout1, exp_head()); end
            checks++; if (empty0 !== (i == 8)) begin errors++; $display("FAIL drain_empty got %0b exp %0b", empty0, (i == 8)); end
        end
        step(1'b0, 1'b1, '0);
        checks++; if (unf0 !== 1'b1) begin errors++; $display("FAIL unf_pulse got %0b exp 1", unf0); end
        checks++; if (dout0 !== 16'h0008) begin errors++; $display("FAIL unf_hold got %0h exp 8", dout0); end
        step(1'b0, 1'b0, '0);
        checks++; if (unf0 !== 1'b0) begin errors++; $display("FAIL unf_one_cycle got %0b exp 0", unf0); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'($urandom));
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 16'($urandom));
            checks++; if (dout0 !== m_dout0) begin errors++; $display("FAIL wrap_data got %0h exp %0h", dout0, m_dout0); end
            checks++; if (count0 !== 4'd3) begin errors++; $display("FAIL wrap_count got %0d exp 3", count0); end
            checks++; if (dout1 !== exp_head()) begin errors++; $display("FAIL wrap_fwft got %0h exp %0h", dout1, exp_head()); end
        end
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'($urandom));
        checks++; if (full0 !== 1'b1) begin errors++; $display("FAIL wrap_full got %0b exp 1", full0); end
        step(1'b1, 1'b1, 16'hDEAD);
        checks++; if (count0 !== 4'd7) begin errors++; $display("FAIL both_at_full_count got %0d exp 7", count0); end
        checks++; if (ovf0 !== 1'b1) begin errors++; $display("FAIL both_at_full_ovf got %0b exp 1", ovf0); end
        checks++; if (dout0 !== m_dout0) begin errors++; $display("FAIL both_at_full_data got %0h exp %0h", dout0, m_dout0); end
    endtask

    task automatic test_random();
        bit w, r;
        for (int i = 0; i < 400; i++) begin
            if (i < 200) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 1) != 0);
            end else begin
                w = ($urandom_range(0, 1) != 0);
                r = ($urandom_range(0, 3) != 0);
            end
            step(w, r, 16'($urandom));
            checks++; if (count0 !== 4'(m_q.size())) begin errors++; $display("FAIL rnd_count got %0d exp %0d", count0, m_q.size()); end
            checks++; if (empty0 !== (m_q.size() == 0)) begin errors++; $display("FAIL rnd_empty got %0b exp %0b", empty0, (m_q.size() == 0)); end
            checks++; if (full0 !== (m_q.size() == DEP)) begin errors++; $display("FAIL rnd_full got %0b exp %0b", full0, (m_q.size() == DEP)); end
            checks++; if (af0 !== (m_q.size() >= DEP - 1)) begin errors++; $display("FAIL rnd_af got %0b exp %0b", af0, (m_q.size() >= DEP - 1)); end
            checks++; if (ae0 !== (m_q.size() <= 1)) begin errors++; $display("FAIL rnd_ae got %0b exp %0b", ae0, (m_q.size() <= 1)); end
            checks++; if (ovf0 !== m_ovf || ovf1 !== m_ovf) begin errors++; $display("FAIL rnd_ovf got %0b/%0b exp %0b", ovf0, ovf1, m_ovf); end
            checks++; if (unf0 !== m_unf || unf1 !== m_unf) begin errors++; $display("FAIL rnd_unf got %0b/%0b exp %0b", unf0, unf1, m_unf); end
            checks++; if (dout0 !== m_dout0) begin errors++; $display("FAIL rnd_dout0 got %0h exp %0h", dout0, m_dout0); end
            checks++; if (dout1 !== exp_head()) begin errors++; $display("FAIL rnd_dout1 got %0h exp %0h", dout1, exp_head()); end
            checks++; if (count1 !== count0 || empty1 !== empty0 || full1 !== full0 || af1 !== af0 || ae1 !== ae0) begin
                errors++; $display("FAIL rnd_fwft_flags got count=%0d exp %0d", count1, m_q.size());
            end
        end
    endtask

    task automatic test_fwft();
        while (m_q.size() != 0) step(1'b0, 1'b1, '0);
        step(1'b1, 1'b0, 16'hABCD);
        checks++; if (dout1 !== 16'hABCD) begin errors++; $display("FAIL fwft_visible got %0h exp abcd", dout1); end
        checks++; if (empty1 !== 1'b0) begin errors++; $display("FAIL fwft_empty_low got %0b exp 0", empty1); end
        step(1'b0, 1'b1, '0);
        checks++; if (dout1 !== 16'h0000) begin errors++; $display("FAIL fwft_pop got %0h exp 0", dout1); end
        checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL fwft_empty_high got %0b exp 1", empty1); end
        checks++; if (dout0 !== 16'hABCD) begin errors++; $display("FAIL fwft_reg_path got %0h exp abcd", dout0); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h5000 + 16'(i));
        checks++; if (count0 !== 4'd5) begin errors++; $display("FAIL mid_pre_count got %0d exp 5", count0); end
        @(negedge clk);
        rst  = 1'b1;
        w_en = 1'b1;
        data_in = 16'hBAD0;
        #1;
        checks++; if (count0 !== 4'd0 || count1 !== 4'd0) begin errors++; $display("FAIL mid_count got %0d/%0d exp 0", count0, count1); end
        checks++; if (empty0 !== 1'b1 || full0 !== 1'b0) begin errors++; $display("FAIL mid_flags got e=%0b f=%0b exp 1/0", empty0, full0); end
        checks++; if (ae0 !== 1'b1 || af0 !== 1'b0) begin errors++; $display("FAIL mid_thr got ae=%0b af=%0b exp 1/0", ae0, af0); end
        checks++; if (dout0 !== 16'h0 || dout1 !== 16'h0) begin errors++; $display("FAIL mid_dout got %0h/%0h exp 0", dout0, dout1); end
        @(posedge clk);
        #1;
        checks++; if (empty0 !== 1'b1 || ovf0 !== 1'b0) begin errors++; $display("FAIL mid_drop got e=%0b o=%0b exp 1/0", empty0, ovf0); end
        @(negedge clk);
        rst  = 1'b0;
        w_en = 1'b0;
        model_reset();
        step(1'b1, 1'b0, 16'h1234);
        checks++; if (dout1 !== 16'h1234) begin errors++; $display("FAIL mid_new_fwft got %0h exp 1234", dout1); end
        step(1'b0, 1'b1, '0);
        checks++; if (dout0 !== 16'h1234) begin errors++; $display("FAIL mid_new_data got %0h exp 1234", dout0); end
        checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL mid_new_empty got %0b exp 1", empty0); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_random();
        test_fwft();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
